// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem reads, fills IF/ID.
// Ports: clk/rst, execute redirect, decode ready, imem req/resp, IF/ID out.
module fetch_stage #(
  parameter int               XLEN     = 64,
  parameter int               ILEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            id_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instr_out,
  output logic [6:0]      opcode_out,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  logic slot_free;
  logic load;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    pc_out_d  = pc_out_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    imem_req  = 1'b0;
    load      = 1'b0;
    slot_free = !valid_q || id_ready;

    unique case (state_q)
      FETCH: begin
        imem_req = slot_free;
        if (branch_taken) begin
          valid_d = 1'b0;
          pc_d    = branch_target;
        end else if (slot_free) begin
          if (imem_rvalid) begin
            load = 1'b1;
          end else begin
            // Entry (if any) is consumed this cycle.
            valid_d = 1'b0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          valid_d = 1'b0;
          if (imem_rvalid) begin
            pc_d    = branch_target;
            state_d = FETCH;
          end else begin
            tgt_d   = branch_target;
            state_d = DRAIN;
          end
        end else if (imem_rvalid) begin
          load    = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // Old request must complete before redirecting; data is dropped.
        imem_req = 1'b1;
        valid_d  = 1'b0;
        if (branch_taken) tgt_d = branch_target;
        if (imem_rvalid) begin
          pc_d    = branch_taken ? branch_target : tgt_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (load) begin
      instr_d  = imem_rdata;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_q + XLEN'(4);
    end

    if (rst) imem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      pc_out_q <= '0;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign opcode_out  = instr_q[6:0];
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameters: RESET_PC, default 64'h0, first fetch address; XLEN, default 64, address width; ILEN, default 32, instruction width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: branch_taken  input  1  redirect request from execute (beq resolved taken).
REQ-006 Port: branch_target  input  XLEN  redirect address, valid with branch_taken.
REQ-007 Port: id_ready  input  1  decode accepts the IF/ID entry this cycle.
REQ-008 Port: imem_req  output  1  instruction memory read request.
REQ-009 Port: imem_addr  output  XLEN  read address, stable while imem_req=1 until response.
REQ-010 Port: imem_rvalid  input  1  read data valid; may assert in the same cycle as imem_req or later.
REQ-011 Port: imem_rdata  input  ILEN  instruction word, valid with imem_rvalid.
REQ-012 Port: instr_out  output  ILEN  IF/ID instruction register.
REQ-013 Port: opcode_out  output  7  instr_out[6:0], feeds the main decoder.
REQ-014 Port: pc_out  output  XLEN  address of instr_out.
REQ-015 Port: instr_valid  output  1  IF/ID entry holds a live instruction.

Function
REQ-016 FSM states SHALL be FETCH, WAIT, DRAIN; reset state FETCH.
REQ-017 Slot "free" SHALL mean instr_valid=0, or instr_valid=1 and id_ready=1 (consumed this cycle).
REQ-018 FETCH: imem_req=1 with imem_addr=pc only when the slot is free; otherwise imem_req=0.
REQ-019 FETCH with request and imem_rvalid=1: load instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4; stay FETCH (one instruction per cycle with zero-latency memory).
REQ-020 FETCH with request and imem_rvalid=0: go to WAIT; a consumed entry clears instr_valid at that edge.
REQ-021 WAIT: imem_req=1, imem_addr unchanged; on imem_rvalid=1 load as in REQ-019 and return to FETCH; the slot is always empty in WAIT.
REQ-022 Consumption without a load (instr_valid=1, id_ready=1, no rvalid accepted) SHALL clear instr_valid.
REQ-023 branch_taken SHALL have priority over every other event: instr_valid<=0, and no response arriving that cycle is loaded.
REQ-024 branch_taken in FETCH (with or without rvalid), or in WAIT with imem_rvalid=1: pc<=branch_target, next state FETCH.
REQ-025 branch_taken in WAIT with imem_rvalid=0: save branch_target, go to DRAIN.
REQ-026 DRAIN: imem_req=1 at the old address until imem_rvalid=1; discard the data, pc<=saved target, go to FETCH; a further branch_taken in DRAIN replaces the saved target.
REQ-027 pc+4 SHALL wrap modulo 2^XLEN; there are no alignment checks.
REQ-028 opcode_out SHALL always equal instr_out[6:0].

Reset
REQ-029 On rst=1 at an edge: pc=RESET_PC, state=FETCH, instr_valid=0, instr_out=32'h00000013 (nop), pc_out=0, saved target=0; imem_req=0 while rst=1.
REQ-030 rst SHALL override branch_taken and imem_rvalid in the same cycle; a response pending at reset is dropped and not loaded afterwards.

Verification
REQ-031 Zero-latency memory, id_ready=1, RESET_PC=0 -> pc_out 0,4,8,12 on consecutive cycles, instr_valid=1 from the first edge after reset release.
REQ-032 id_ready=0 for 3 cycles with entry at pc 8 -> imem_req=0, instr_out/pc_out held at 8; id_ready=1 -> next entry pc 12 on the following edge.
REQ-033 Memory latency 2 cycles -> imem_addr held for 3 cycles, one entry every 3 cycles, no duplicate or skipped PC.
REQ-034 branch_taken, target 0x100, while in WAIT (rvalid 1 cycle later) -> stale response discarded, instr_valid=0, next request address 0x100.
REQ-035 branch_taken and imem_rvalid in the same FETCH cycle -> data not loaded, next imem_addr=target.
REQ-036 rst asserted in WAIT -> instr_out=0x00000013, instr_valid=0, first request after release at RESET_PC.
